// File: rtl/echo_module.sv
// Feedforward echo: delays the 12-bit signed input through a circular buffer, attenuates the
// delayed copy and mixes it back in with saturation. One sample per three-cycle IDLE/READ/MIX pass.
module echo_module #(
  parameter int SAMPLING_RATE = 24000,
  parameter int DEPTH_LOG2    = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [11:0]           incoming_sample,
  input  logic [1:0]            delay_select,
  input  logic [1:0]            decay,
  input  logic                  enable,
  output logic [11:0]           modified_sample,
  output logic                  done,
  output logic [1:0]            o_dbg_state,
  output logic [DEPTH_LOG2-1:0] o_dbg_wr_ptr,
  output logic [DEPTH_LOG2:0]   o_dbg_fill_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] TAP_F = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] TAP_H = TAP_F >> 1;
  localparam logic [DEPTH_LOG2:0] TAP_Q = TAP_F >> 2;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, MIX = 2'd2} state_t;

  state_t                  r_state, w_next_state;
  logic [11:0]             r_sample;
  logic [1:0]              r_sel;
  logic [1:0]              r_decay;
  logic                    r_enable;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_addr;
  logic [DEPTH_LOG2:0]     r_fill;
  logic [11:0]             r_rd_data;
  logic [11:0]             r_mem [DEPTH];
  logic [11:0]             r_out;
  logic                    r_done;

  logic [DEPTH_LOG2:0]     w_tap_in, w_tap_lat;
  logic                    w_echo_on;
  logic [2:0]              w_shamt;
  logic signed [11:0]      w_delayed, w_echo;
  logic signed [12:0]      w_sum;
  logic [11:0]             w_sat;

  function automatic logic [DEPTH_LOG2:0] tap_of(input logic [1:0] sel);
    case (sel)
      2'b01:   tap_of = TAP_Q;
      2'b10:   tap_of = TAP_H;
      default: tap_of = TAP_F;
    endcase
  endfunction

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = READ;
      READ:    w_next_state = MIX;
      MIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  assign w_tap_in  = tap_of(delay_select);
  assign w_tap_lat = tap_of(r_sel);

  // Stale buffer contents are never used: the tap must lie within the samples written so far.
  assign w_echo_on = r_enable && (r_sel != 2'b00) && (r_fill >= w_tap_lat);
  assign w_shamt   = {1'b0, r_decay} + 3'd1;
  assign w_delayed = r_rd_data;
  assign w_echo    = w_echo_on ? (w_delayed >>> w_shamt) : 12'sd0;
  assign w_sum     = {r_sample[11], r_sample} + {w_echo[11], w_echo};

  always_comb begin
    w_sat = w_sum[11:0];
    if (w_sum[12] != w_sum[11]) w_sat = w_sum[12] ? 12'h800 : 12'h7FF;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sample  <= '0;
      r_sel     <= '0;
      r_decay   <= '0;
      r_enable  <= 1'b0;
      r_rd_addr <= '0;
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_out     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && start) begin
        r_sample  <= incoming_sample;
        r_sel     <= delay_select;
        r_decay   <= decay;
        r_enable  <= enable;
        r_rd_addr <= r_wr_ptr - w_tap_in[DEPTH_LOG2-1:0];
      end
      if (r_state == MIX) begin
        r_out    <= w_sat;
        r_done   <= 1'b1;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_fill != TAP_F) r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Buffer has no reset; a reset forces IDLE so an in-flight sample is never written.
  always_ff @(posedge clock) begin
    if (r_state == READ) r_rd_data <= r_mem[r_rd_addr];
    if (r_state == MIX)  r_mem[r_wr_ptr] <= r_sample;
  end

  assign modified_sample  = r_out;
  assign done             = r_done;
  assign o_dbg_state      = r_state;
  assign o_dbg_wr_ptr     = r_wr_ptr;
  assign o_dbg_fill_count = r_fill;

endmodule

// File: tb/tb_echo_module.sv
// Bench for echo_module at DEPTH=8: fixed vector table, reset/busy corner sequences, and
// randomized traffic checked against a history-queue reference model.
module tb_echo_module;

  localparam int DL    = 3;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [11:0]   incoming_sample;
  logic [1:0]    delay_select;
  logic [1:0]    decay;
  logic          enable;
  logic [11:0]   modified_sample;
  logic          done;
  logic [1:0]    o_dbg_state;
  logic [DL-1:0] o_dbg_wr_ptr;
  logic [DL:0]   o_dbg_fill_count;

  echo_module #(.SAMPLING_RATE(24000), .DEPTH_LOG2(DL)) dut (
    .clock(clock), .reset(reset), .start(start), .incoming_sample(incoming_sample),
    .delay_select(delay_select), .decay(decay), .enable(enable),
    .modified_sample(modified_sample), .done(done), .o_dbg_state(o_dbg_state),
    .o_dbg_wr_ptr(o_dbg_wr_ptr), .o_dbg_fill_count(o_dbg_fill_count)
  );

  always #5 clock = ~clock;

  int         errors = 0;
  int         checks = 0;
  int         hist[$];
  logic [11:0] exp_q[$];

  typedef struct {
    bit rst; int s; int sel; int dec; int en; int exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: echo = history[n - tap] divided by 2^(decay+1) rounded toward -inf, clamped sum.
  function automatic int model_step(input int s, input int sel, input int dec, input int en);
    int tap, e, d, dv, sum;
    tap = (sel == 1) ? DEPTH / 4 : (sel == 2) ? DEPTH / 2 : DEPTH;
    e = 0;
    if (en != 0 && sel != 0 && hist.size() >= tap) begin
      d  = hist[hist.size() - tap];
      dv = 1 << (dec + 1);
      e  = (d >= 0) ? d / dv : -((-d + dv - 1) / dv);
    end
    sum = s + e;
    if (sum > 2047)  sum = 2047;
    if (sum < -2048) sum = -2048;
    hist.push_back(s);
    return sum;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    hist.delete();
  endtask

  task automatic send(input int s, input int sel, input int dec, input int en,
                      output int got, output int lat);
    @(negedge clock);
    start = 1'b1;
    incoming_sample = 12'(s);
    delay_select = 2'(sel);
    decay = 2'(dec);
    enable = en[0];
    @(negedge clock);
    start = 1'b0;
    incoming_sample = 12'($urandom_range(0, 4095));
    delay_select = 2'($urandom_range(0, 3));
    decay = 2'($urandom_range(0, 3));
    enable = 1'($urandom_range(0, 1));
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    got = int'($signed(modified_sample));
  endtask

  task automatic apply(input string name, input int s, input int sel, input int dec,
                       input int en, input int exp);
    int got, lat;
    send(s, sel, dec, en, got, lat);
    check({name, "_latency"}, lat, 3);
    check({name, "_value"}, got, exp);
    @(negedge clock);
    check({name, "_done_low"}, int'(done), 0);
  endtask

  initial begin
    int got, lat, nd, m;
    reset = 1'b0; start = 1'b0; incoming_sample = '0;
    delay_select = '0; decay = '0; enable = 1'b0;

    do_reset();
    check("rst_out", int'(modified_sample), 0);
    check("rst_done", int'(done), 0);
    check("rst_fill", int'(o_dbg_fill_count), 0);

    apply("bypass", -1234, 1, 0, 0, model_step(-1234, 1, 0, 0));
    check("bypass_abs", int'($signed(modified_sample)), -1234);

    // Reset while the next sample sits in MIX.
    @(negedge clock);
    start = 1'b1; incoming_sample = 12'(500); enable = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("pre_rst_state_mix", int'(o_dbg_state), 2);
    #1 reset = 1'b1;
    #1;
    check("midrst_out", int'(modified_sample), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_wrptr", int'(o_dbg_wr_ptr), 0);
    check("midrst_fill", int'(o_dbg_fill_count), 0);
    check("midrst_state", int'(o_dbg_state), 0);
    @(negedge clock);
    reset = 1'b0;
    hist.delete();
    repeat (3) @(negedge clock);
    check("post_rst_fill", int'(o_dbg_fill_count), 0);

    // Reset during the done pulse.
    send(321, 0, 0, 0, got, lat);
    check("pulse_seen", int'(done), 1);
    #1 reset = 1'b1;
    #1 check("pulse_drop", int'(done), 0);
    @(negedge clock);
    reset = 1'b0;
    hist.delete();

    tbl.push_back('{1, 1000, 1, 0, 1, 1000});
    tbl.push_back('{0, 0,    1, 0, 1, 0});
    tbl.push_back('{0, 0,    1, 0, 1, 500});
    tbl.push_back('{0, 0,    1, 0, 1, 0});
    tbl.push_back('{1, 1000, 1, 3, 1, 1000});
    tbl.push_back('{0, 0,    1, 3, 1, 0});
    tbl.push_back('{0, 0,    1, 3, 1, 62});
    tbl.push_back('{0, 0,    1, 3, 1, 0});
    tbl.push_back('{1, 0, 3, 0, 1, 0});
    for (int i = 0; i < 7; i++) tbl.push_back('{0, 0, 3, 0, 1, 0});
    tbl.push_back('{0, 800, 3, 0, 1, 800});
    tbl.push_back('{1, 800, 3, 0, 1, 800});
    for (int i = 0; i < 7; i++) tbl.push_back('{0, 800, 3, 0, 1, 800});
    tbl.push_back('{0, 800, 3, 0, 1, 1200});
    tbl.push_back('{1, 2000,  1, 0, 1, 2000});
    tbl.push_back('{0, 2000,  1, 0, 1, 2000});
    tbl.push_back('{0, 2000,  1, 0, 1, 2047});
    tbl.push_back('{1, -2000, 1, 0, 1, -2000});
    tbl.push_back('{0, -2000, 1, 0, 1, -2000});
    tbl.push_back('{0, -2000, 1, 0, 1, -2048});
    tbl.push_back('{1, -3, 1, 0, 1, -3});
    tbl.push_back('{0, -3, 1, 0, 1, -3});
    tbl.push_back('{0, -3, 1, 0, 1, -5});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      m = model_step(tbl[i].s, tbl[i].sel, tbl[i].dec, tbl[i].en);
      apply($sformatf("vec%0d", i), tbl[i].s, tbl[i].sel, tbl[i].dec, tbl[i].en, tbl[i].exp);
    end

    // start held high every cycle: only every third is accepted.
    do_reset();
    exp_q.delete();
    nd = 0;
    delay_select = 2'b01; decay = 2'b00; enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      start = 1'b1;
      incoming_sample = 12'((i + 1) * 100);
      if (i % 3 == 0) exp_q.push_back(12'(model_step((i + 1) * 100, 1, 0, 1)));
      @(negedge clock);
      if (done) begin
        nd++;
        if (exp_q.size() > 0) check("busy_out", int'(modified_sample), int'(exp_q.pop_front()));
      end
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) begin
        nd++;
        if (exp_q.size() > 0) check("busy_out", int'(modified_sample), int'(exp_q.pop_front()));
      end
    end
    check("busy_count", nd, 3);

    // Wrap with full-depth tap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      int s, dec;
      s = int'($urandom_range(0, 4095)) - 2048;
      dec = int'($urandom_range(0, 3));
      apply($sformatf("wrap%0d", i), s, 3, dec, 1, model_step(s, 3, dec, 1));
    end
    check("wrap_wrptr", int'(o_dbg_wr_ptr), 4);
    check("wrap_fill", int'(o_dbg_fill_count), 8);

    for (int i = 0; i < 60; i++) begin
      int s, sel, dec, en;
      s   = int'($urandom_range(0, 4095)) - 2048;
      sel = int'($urandom_range(0, 3));
      dec = int'($urandom_range(0, 3));
      en  = int'($urandom_range(0, 3) != 0);
      apply($sformatf("rand%0d", i), s, sel, dec, en, model_step(s, sel, dec, en));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
